// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between two writeback
//   sources (0: ALU/EX, 1: load / multi-cycle unit). Each source feeds its
//   own DEPTH-entry FIFO. A round-robin arbiter drains one entry per cycle
//   into registered write-port outputs. A combinational hazard check flags
//   reads of registers that still have a write in flight.
//
// Ports
//   clk, reset                 clock; asynchronous active-low reset
//   sN_valid/addr/data/ready   source N write offer and FIFO-not-full
//   rf_we/rf_waddr/rf_wdata    registered register-file write port
//   chk_addr1/chk_addr2        read addresses to hazard-check
//   hazard                     a checked address has a pending write
//   idle                       both FIFOs empty and rf_we low
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s0_valid,
  input  logic [AW-1:0] s0_addr,
  input  logic [DW-1:0] s0_data,
  output logic          s0_ready,
  input  logic          s1_valid,
  input  logic [AW-1:0] s1_addr,
  input  logic [DW-1:0] s1_data,
  output logic          s1_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] chk_addr1,
  input  logic [AW-1:0] chk_addr2,
  output logic          hazard,
  output logic          idle
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [1:0]                         in_vld;
  logic [1:0][AW-1:0]                 in_addr;
  logic [1:0][DW-1:0]                 in_data;

  logic [1:0][DEPTH-1:0][AW-1:0]      addr_q;
  logic [1:0][DEPTH-1:0][DW-1:0]      data_q;
  logic [1:0][PW-1:0]                 wr_ptr_q, rd_ptr_q;
  logic [1:0][CW-1:0]                 cnt_q, cnt_d;
  logic                               last_grant_q, last_grant_d;
  logic                               rf_we_q, rf_we_d;
  logic [AW-1:0]                      rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]                      rf_wdata_q, rf_wdata_d;

  logic [1:0]                         empty, full, push, pop;
  logic                               gnt_vld, gnt_sel;
  logic [PW-1:0]                      off;
  logic                               hit1, hit2;

  assign in_vld  = {s1_valid, s0_valid};
  assign in_addr = {s1_addr, s0_addr};
  assign in_data = {s1_data, s0_data};

  // Ready looks only at registered occupancy: a pop this cycle does not
  // open a slot until the next cycle. Register-0 writes are accepted but
  // dropped on the floor.
  always_comb begin
    empty = '0;
    full  = '0;
    push  = '0;
    for (int s = 0; s < 2; s++) begin
      empty[s] = (cnt_q[s] == '0);
      full[s]  = (cnt_q[s] == CW'(DEPTH));
      push[s]  = in_vld[s] & ~full[s] & (in_addr[s] != '0);
    end
  end

  // Round robin: a lone non-empty FIFO wins outright; under contention the
  // source that did not win last time goes.
  always_comb begin
    gnt_vld = ~(empty[0] & empty[1]);
    if (!empty[0] && !empty[1]) gnt_sel = ~last_grant_q;
    else                        gnt_sel = empty[0];
    pop = '0;
    if (gnt_vld) pop[gnt_sel] = 1'b1;

    last_grant_d = last_grant_q;
    rf_we_d      = gnt_vld;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    if (gnt_vld) begin
      last_grant_d = gnt_sel;
      rf_waddr_d   = addr_q[gnt_sel][rd_ptr_q[gnt_sel]];
      rf_wdata_d   = data_q[gnt_sel][rd_ptr_q[gnt_sel]];
    end

    for (int s = 0; s < 2; s++)
      cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q       <= '0;
      data_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          addr_q[s][wr_ptr_q[s]] <= in_addr[s];
          data_q[s][wr_ptr_q[s]] <= in_data[s];
          wr_ptr_q[s]            <= wr_ptr_q[s] + 1'b1;
        end
        if (pop[s]) rd_ptr_q[s] <= rd_ptr_q[s] + 1'b1;
      end
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  // An entry is live when its distance from the read pointer (mod DEPTH)
  // is below the occupancy. Entries being pushed this cycle are not seen.
  always_comb begin
    hit1 = rf_we_q && (rf_waddr_q == chk_addr1);
    hit2 = rf_we_q && (rf_waddr_q == chk_addr2);
    off  = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        off = PW'(i) - rd_ptr_q[s];
        if (CW'(off) < cnt_q[s]) begin
          if (addr_q[s][i] == chk_addr1) hit1 = 1'b1;
          if (addr_q[s][i] == chk_addr2) hit2 = 1'b1;
        end
      end
    end
    hazard = (hit1 && (chk_addr1 != '0)) || (hit2 && (chk_addr2 != '0));
  end

  assign s0_ready = ~full[0];
  assign s1_ready = ~full[1];
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign idle     = empty[0] & empty[1] & ~rf_we_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          s0_valid, s1_valid;
  logic [AW-1:0] s0_addr, s1_addr;
  logic [DW-1:0] s0_data, s1_data;
  logic          s0_ready, s1_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] chk_addr1, chk_addr2;
  logic          hazard, idle;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  passed = 0;
  int  total  = 0;

  regfile_wb_arbiter #(.DEPTH(2), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_data(s1_data), .s1_ready(s1_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .hazard(hazard), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 20 && !idle; k++) step();
    chk(tag, 64'(idle), 64'd1);
  endtask

  // Scoreboard: every write seen on the port must be the next expected one.
  always @(negedge clk) begin
    if (reset === 1'b1 && rf_we === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", 64'({rf_waddr, rf_wdata}), 64'd0);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wb", 64'({rf_waddr, rf_wdata}), 64'({e.a, e.d}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int i0, i1;
    logic a0, a1;
    logic [11:0] we_h, r0_h, r1_h;

    reset = 1'b0;
    s0_valid = 0; s0_addr = '0; s0_data = '0;
    s1_valid = 0; s1_addr = '0; s1_data = '0;
    chk_addr1 = '0; chk_addr2 = '0;
    step(); step();

    // Reset state
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_s0_ready", 64'(s0_ready), 64'd1);
    chk("rst_s1_ready", 64'(s1_ready), 64'd1);
    chk("rst_hazard", 64'(hazard), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    reset = 1'b1;
    step();

    // Contention straight out of reset: source 0 wins first
    exp_q.push_back({5'd1,  32'h101});
    exp_q.push_back({5'd9,  32'h909});
    exp_q.push_back({5'd2,  32'h102});
    exp_q.push_back({5'd10, 32'h90a});
    exp_q.push_back({5'd3,  32'h103});
    exp_q.push_back({5'd11, 32'h90b});
    i0 = 0; i1 = 0;
    for (int c = 0; c < 12; c++) begin
      we_h[c] = rf_we; r0_h[c] = s0_ready; r1_h[c] = s1_ready;
      s0_valid = (i0 < 3); s0_addr = AW'(1 + i0); s0_data = 32'h101 + 32'(i0);
      s1_valid = (i1 < 3); s1_addr = AW'(9 + i1); s1_data = 32'h909 + 32'(i1);
      a0 = s0_valid & s0_ready;
      a1 = s1_valid & s1_ready;
      step();
      if (a0) i0++;
      if (a1) i1++;
    end
    s0_valid = 0; s1_valid = 0;
    chk("cont_we_hist", 64'(we_h), 64'h0fc);
    chk("cont_s0_ready_hist", 64'(r0_h), 64'hff7);
    chk("cont_s1_ready_hist", 64'(r1_h), 64'hfeb);
    wait_idle("cont_idle");

    // Single write
    s0_valid = 1; s0_addr = 5'd5; s0_data = 32'h1234;
    chk("single_ready", 64'(s0_ready), 64'd1);
    exp_q.push_back({5'd5, 32'h1234});
    step();
    s0_valid = 0;
    chk("single_we_n", 64'(rf_we), 64'd0);
    chk("single_idle_n", 64'(idle), 64'd0);
    step();
    chk("single_we", 64'(rf_we), 64'd1);
    chk("single_waddr", 64'(rf_waddr), 64'd5);
    chk("single_wdata", 64'(rf_wdata), 64'h1234);
    step();
    chk("single_we_off", 64'(rf_we), 64'd0);
    chk("single_idle", 64'(idle), 64'd1);
    chk("single_waddr_hold", 64'(rf_waddr), 64'd5);

    // Source 1 alone, back-to-back: drain keeps pace so ready stays high
    for (int k = 0; k < 3; k++) begin
      s1_valid = 1; s1_addr = AW'(20 + k); s1_data = 32'hbeef0000 + 32'(k);
      chk("bp_ready", 64'(s1_ready), 64'd1);
      exp_q.push_back({AW'(20 + k), 32'hbeef0000 + 32'(k)});
      step();
    end
    s1_valid = 0;
    wait_idle("bp_idle");

    // Register 0 is swallowed
    s0_valid = 1; s0_addr = '0; s0_data = 32'hffff_ffff; chk_addr1 = '0;
    chk("r0_ready", 64'(s0_ready), 64'd1);
    step();
    s0_valid = 0;
    chk("r0_hazard", 64'(hazard), 64'd0);
    chk("r0_idle", 64'(idle), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("r0_we", 64'(rf_we), 64'd0);
    end

    // Hazard on a queued / in-flight write
    chk_addr2 = 5'd7;
    s1_valid = 1; s1_addr = 5'd7; s1_data = 32'h77;
    exp_q.push_back({5'd7, 32'h77});
    chk("hz_push_not_seen", 64'(hazard), 64'd0);
    step();
    s1_valid = 0;
    chk("hz_queued", 64'(hazard), 64'd1);
    step();
    chk("hz_inflight_we", 64'(rf_we), 64'd1);
    chk("hz_inflight", 64'(hazard), 64'd1);
    step();
    chk("hz_clear", 64'(hazard), 64'd0);
    chk_addr2 = 5'd8;
    s1_valid = 1; s1_addr = 5'd7; s1_data = 32'h78;
    exp_q.push_back({5'd7, 32'h78});
    step();
    s1_valid = 0;
    chk("hz_other_queued", 64'(hazard), 64'd0);
    step();
    chk("hz_other_inflight", 64'(hazard), 64'd0);
    wait_idle("hz_idle");

    // Reset mid-operation: queued and in-flight writes vanish
    chk_addr1 = 5'd13;
    s0_valid = 1; s0_addr = 5'd12; s0_data = 32'hc0;
    s1_valid = 1; s1_addr = 5'd24; s1_data = 32'hd0;
    step();
    s0_addr = 5'd13; s0_data = 32'hc1;
    s1_addr = 5'd25; s1_data = 32'hd1;
    step();
    s0_valid = 0; s1_valid = 0;
    chk("mid_we_before", 64'(rf_we), 64'd1);
    chk("mid_hazard_before", 64'(hazard), 64'd1);
    chk("mid_s1_full", 64'(s1_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("mid_we", 64'(rf_we), 64'd0);
    chk("mid_waddr", 64'(rf_waddr), 64'd0);
    chk("mid_idle", 64'(idle), 64'd1);
    chk("mid_s0_ready", 64'(s0_ready), 64'd1);
    chk("mid_s1_ready", 64'(s1_ready), 64'd1);
    chk("mid_hazard", 64'(hazard), 64'd0);
    step();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_we", 64'(rf_we), 64'd0);
      chk("post_rst_idle", 64'(idle), 64'd1);
    end

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
